// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
//   Shared types and constants for the sequential multi-lane shifter.
//   shift_mode_e : encoding of the in_mode port (SLL, SRL, SRA, ROR).
//   fsm_state_e  : control states of shifter_seq_nch.
//   SHIFT_MODE_W : width of the mode field.
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int SHIFT_MODE_W = 2;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } fsm_state_e;

endpackage : shifter_pkg

// File: rtl/shifter_lane_step.sv
// ---------------------------------------------------------------------------
// shifter_lane_step
//   Combinational single-lane step: shifts one W-bit lane by k (0..STEP)
//   positions in the requested mode.
//   Optional feature macro: SHIFTER_ROTATE_EN (mode ROR rotates right within
//   the lane; when undefined, ROR is treated as SRL and no rotate logic exists).
// Ports
//   lane_i  in   W     lane value before this step
//   k_i     in   KW    positions to shift this step (never exceeds STEP)
//   mode_i  in   mode  SLL / SRL / SRA / ROR
//   lane_o  out  W     lane value after this step
// ---------------------------------------------------------------------------
module shifter_lane_step
    import shifter_pkg::*;
#(
    parameter int W    = 8,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [W-1:0]  lane_i,
    input  logic [KW-1:0] k_i,
    input  shift_mode_e   mode_i,
    output logic [W-1:0]  lane_o
);

`ifdef SHIFTER_ROTATE_EN
    logic [2*W-1:0] rot;
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        lane_o = lane_i;
`ifdef SHIFTER_ROTATE_EN
        rot    = '0;
`endif
        unique case (mode_i)
            SH_SLL: lane_o = lane_i << k_i;
            SH_SRL: lane_o = lane_i >> k_i;
            // The lane MSB is preserved by every arithmetic step, so the sign
            // seen here is always the one captured at accept.
            SH_SRA: lane_o = W'($signed(lane_i) >>> k_i);
`ifdef SHIFTER_ROTATE_EN
            SH_ROR: begin
                // Doubling the lane lets a plain right shift bring the low
                // bits around into the top of the result.
                rot    = {lane_i, lane_i} >> k_i;
                lane_o = rot[W-1:0];
            end
`else
            SH_ROR: lane_o = lane_i >> k_i;
`endif
            default: lane_o = lane_i;
        endcase
    end

endmodule : shifter_lane_step

// File: rtl/shifter_seq_nch.sv
// ---------------------------------------------------------------------------
// shifter_seq_nch
//   Iterative NCH-lane shifter. All lanes shift by a common run-time amount,
//   at most STEP positions per clock, with valid/ready on input and output
//   and a single operation in flight.
//   Optional feature macro: SHIFTER_ROTATE_EN (enables ROR for mode 11).
// Parameters
//   W     lane width (power of two, >= 2)
//   NCH   number of lanes (>= 1)
//   STEP  max positions shifted per cycle (1..W)
//   SHW   shift-amount width, derived from W
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   in_valid   in   1       request valid
//   in_ready   out  1       high only in IDLE and out of reset
//   in_data    in   NCH*W   packed lanes, lane i = in_data[i*W +: W]
//   in_amt     in   SHW     shift amount 0..W-1
//   in_mode    in   2       00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL
//   out_valid  out  1       result valid, held until out_ready
//   out_ready  in   1       result consumed on out_valid & out_ready
//   out_data   out  NCH*W   shifted lanes
//   busy       out  1       high in SHIFT or DONE
// ---------------------------------------------------------------------------
module shifter_seq_nch
    import shifter_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int NCH  = 2,
    parameter  int STEP = 1,
    localparam int SHW  = $clog2(W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCH*W-1:0]        in_data,
    input  logic [SHW-1:0]          in_amt,
    input  logic [SHIFT_MODE_W-1:0] in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*W-1:0]        out_data,
    output logic                    busy
);

    localparam int KW = $clog2(STEP + 1);

    fsm_state_e         state_q;
    shift_mode_e        mode_q;
    logic [SHW-1:0]     remaining_q;
    logic [SHW-1:0]     remaining_d;
    logic [NCH*W-1:0]   data_q;
    logic [NCH*W-1:0]   data_d;
    logic               out_valid_q;
    logic [KW-1:0]      k;

    // Ready is purely a function of state so upstream never sees it depend
    // on its own valid; it is also forced low while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

    // Step size for this cycle: full STEP until the tail, then the remainder.
    always_comb begin
        if (int'(remaining_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(remaining_q);
        end
        // k never exceeds remaining_q (< W), so it fits in SHW bits.
        remaining_d = remaining_q - SHW'(k);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        shifter_lane_step #(
            .W    (W),
            .STEP (STEP),
            .KW   (KW)
        ) u_lane (
            .lane_i (data_q[i*W +: W]),
            .k_i    (k),
            .mode_i (mode_q),
            .lane_o (data_d[i*W +: W])
        );
    end

    // NOTE: reset is tested inside the clocked block, so it only takes effect
    // on a rising edge; there is deliberately no rst_n in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= ST_IDLE;
            mode_q      <= SH_SLL;
            remaining_q <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q      <= in_data;
                        mode_q      <= shift_mode_e'(in_mode);
                        remaining_q <= in_amt;
                        state_q     <= (in_amt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_q      <= data_d;
                    remaining_q <= remaining_d;
                    if (remaining_d == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises out_valid; it then holds with
                    // data frozen until the consumer takes it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : shifter_seq_nch

// File: tb/tb_shifter_seq_nch.sv
// ---------------------------------------------------------------------------
// tb_shifter_seq_nch
//   Two shifter instances (STEP=1 and STEP=4, W=8, NCH=2) on a shared clock
//   and reset. Drivers push expected results and latencies into per-instance
//   queues; a monitor pops and compares whenever a result is presented.
// ---------------------------------------------------------------------------
module tb_shifter_seq_nch;

    localparam int DW = 16;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [DW-1:0] EXP_M11_S1 = 16'hC0C0;
    localparam logic [DW-1:0] EXP_M11_S4 = 16'h0C78;
`else
    localparam logic [DW-1:0] EXP_M11_S1 = 16'h4040;
    localparam logic [DW-1:0] EXP_M11_S4 = 16'h0400;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
        int            acc;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic [2:0]    in_amt    [2];
    logic [1:0]    in_mode   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic          busy      [2];

    exp_t          exp_q [2][$];
    bit            seen  [2];
    logic [DW-1:0] held  [2];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shifter_seq_nch #(.W(8), .NCH(2), .STEP(1)) u_dut_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_amt    (in_amt[0]),
        .in_mode   (in_mode[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0])
    );

    shifter_seq_nch #(.W(8), .NCH(2), .STEP(4)) u_dut_s4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_amt    (in_amt[1]),
        .in_mode   (in_mode[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Monitor: compares each presented result against the queue head.
    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                seen[d] = 1'b0;
            end else if (out_valid[d]) begin
                if (!seen[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out dut%0d: out_valid with data %0h, required no result",
                                 d, out_data[d]);
                    end else begin
                        seen[d] = 1'b1;
                        held[d] = out_data[d];
                        check({exp_q[d][0].name, "_latency"}, cyc - exp_q[d][0].acc, exp_q[d][0].lat);
                        check({exp_q[d][0].name, "_data"}, 32'(out_data[d]), 32'(exp_q[d][0].data));
                    end
                end else begin
                    check("stall_data_hold", 32'(out_data[d]), 32'(held[d]));
                end
                if (out_ready[d] && seen[d]) begin
                    void'(exp_q[d].pop_front());
                    seen[d] = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int d, input logic [DW-1:0] data, input logic [2:0] amt,
                         input logic [1:0] mode, input logic [DW-1:0] want, input int lat,
                         input string name);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready[d] && guard < 100);
        if (!in_ready[d]) begin
            n_checks++;
            $display("FAIL %s_accept_timeout: in_ready stayed 0, required 1", name);
            return;
        end
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_amt[d]   = amt;
        in_mode[d]  = mode;
        exp_q[d].push_back('{data: want, lat: lat, acc: cyc + 1, name: name});
        @(negedge clk);
        // Scramble inputs after accept: the latched operation must not change.
        in_valid[d] = 1'b0;
        in_data[d]  = ~data;
        in_amt[d]   = ~amt;
        in_mode[d]  = ~mode;
        check({name, "_busy"}, 32'(busy[d]), 32'd1);
        check({name, "_in_ready_low"}, 32'(in_ready[d]), 32'd0);
    endtask

    task automatic wait_done(input int d);
        int guard = 0;
        while (exp_q[d].size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q[d].size() != 0) begin
            n_checks++;
            $display("FAIL result_timeout dut%0d: %0d results pending, required 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_amt[d]    = '0;
            in_mode[d]   = '0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rst_in_ready_gated", 32'(in_ready[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check("rst_out_data", 32'(out_data[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
        end

        // STEP=1 instance: directed vectors
        issue(0, 16'h810F, 3'd3, M_SRA, 16'hF001, 4, "s1_sra3");
        wait_done(0);
        issue(0, 16'hA53C, 3'd0, M_SLL, 16'hA53C, 1, "s1_amt0");
        wait_done(0);
        issue(0, 16'h01FE, 3'd7, M_SLL, 16'h8000, 8, "s1_sll7");
        wait_done(0);
        issue(0, 16'h807F, 3'd7, M_SRA, 16'hFF00, 8, "s1_sra7");
        wait_done(0);
        issue(0, 16'h8181, 3'd1, M_ROR, EXP_M11_S1, 2, "s1_mode11");
        wait_done(0);

        // STEP=4 instance: multi-position steps
        issue(1, 16'hFF80, 3'd7, M_SRL, 16'h0101, 3, "s4_srl7");
        wait_done(1);
        issue(1, 16'h9060, 3'd5, M_SRA, 16'hFC03, 3, "s4_sra5");
        wait_done(1);
        issue(1, 16'h3C5A, 3'd4, M_SLL, 16'hC0A0, 2, "s4_sll4");
        wait_done(1);
        issue(1, 16'h8001, 3'd1, M_SRL, 16'h4000, 2, "s4_srl1");
        wait_done(1);
        issue(1, 16'h810F, 3'd5, M_ROR, EXP_M11_S4, 3, "s4_mode11");
        wait_done(1);

        // Back-pressure: result held in DONE, new requests refused
        out_ready[0] = 1'b0;
        issue(0, 16'hF00F, 3'd2, M_SRL, 16'h3C03, 3, "stall");
        guard = 0;
        while (!out_valid[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_valid_seen", 32'(out_valid[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            in_data[0]  = 16'hDEAD;
            in_amt[0]   = 3'd1;
            #1;
            check("stall_in_ready_low", 32'(in_ready[0]), 32'd0);
            check("stall_out_valid_held", 32'(out_valid[0]), 32'd1);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        #2;
        check("post_hs_out_valid", 32'(out_valid[0]), 32'd0);
        check("post_hs_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_hs_queue_empty", 32'(exp_q[0].size()), 32'd0);

        // Reset in the middle of a shift: operation discarded
        issue(0, 16'h1111, 3'd6, M_SLL, 16'h4040, 7, "rst_op");
        @(negedge clk);
        check("rst_op_busy_mid", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_out_data", 32'(out_data[0]), 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_result", 32'(out_valid[0]), 32'd0);

        // Recovery after reset
        issue(0, 16'h4080, 3'd1, M_SRA, 16'h20C0, 2, "recover_sra1");
        wait_done(0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shifter_seq_nch
